// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - Fibonacci LFSR word generator with seed load, enable stepping and valid/ready output
// Optional wrap-period detection when LFSR_WRAP_DET_EN is defined (adds wrap_pulse).
module lfsr_rng #(
    parameter int          WIDTH    = 16,
    parameter logic [31:0] TAPS     = 32'h0000_B400,
    parameter logic [31:0] SEED     = 32'h0000_FFFF,
    parameter int          OUT_BITS = 4,
    parameter int          STEPS    = 4
) (
    input  logic                clk,
    input  logic                preset_n,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic [WIDTH-1:0]    state_q,
    output logic                lockup
`ifdef LFSR_WRAP_DET_EN
    ,
    output logic                wrap_pulse
`endif
);

    localparam int              CW       = $clog2(STEPS + 1);
    localparam logic [CW-1:0]   LAST     = CW'(STEPS - 1);
    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V   = SEED[WIDTH-1:0];

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fsm_t;

    fsm_t             fsm;
    logic [CW-1:0]    count;
    logic             fb;
    logic [WIDTH-1:0] next_state;
    logic             seed_zero;
    logic [WIDTH-1:0] load_value;

    always_comb begin
        fb         = ^(state_q & TAP_MASK);
        next_state = {state_q[WIDTH-2:0], fb};
        // A zero seed would lock the register; substitute the reset seed instead.
        seed_zero  = (seed == '0);
        load_value = seed_zero ? SEED_V : seed;
    end

`ifdef LFSR_WRAP_DET_EN
    logic [WIDTH-1:0] loaded;
`endif

    always_ff @(posedge clk) begin
        if (!preset_n) begin
            state_q   <= SEED_V;
            fsm       <= FILL;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            lockup    <= 1'b0;
`ifdef LFSR_WRAP_DET_EN
            loaded     <= SEED_V;
            wrap_pulse <= 1'b0;
`endif
        end else begin
            lockup <= 1'b0;
`ifdef LFSR_WRAP_DET_EN
            wrap_pulse <= 1'b0;
`endif
            if (seed_load) begin
                // Loading overrides any pending word, including one being accepted now.
                state_q   <= load_value;
                lockup    <= seed_zero;
                count     <= '0;
                out_valid <= 1'b0;
                fsm       <= FILL;
`ifdef LFSR_WRAP_DET_EN
                loaded <= load_value;
`endif
            end else begin
                case (fsm)
                    FILL: begin
                        if (enable) begin
                            state_q <= next_state;
`ifdef LFSR_WRAP_DET_EN
                            wrap_pulse <= (next_state == loaded);
`endif
                            if (count == LAST) begin
                                out_data  <= next_state[WIDTH-1 -: OUT_BITS];
                                out_valid <= 1'b1;
                                count     <= '0;
                                fsm       <= HOLD;
                            end else begin
                                count <= count + CW'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            fsm       <= FILL;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - directed vector bench for lfsr_rng (4-bit config) plus period check
module tb_lfsr_rng;

    logic       clk;
    logic       preset_n, enable, seed_load, out_ready;
    logic [3:0] seed;
    logic       out_valid, lockup;
    logic [1:0] out_data;
    logic [3:0] state_q;

    logic       p_preset_n;
    logic       p_out_valid, p_lockup;
    logic [0:0] p_out_data;
    logic [3:0] p_state_q;
`ifdef LFSR_WRAP_DET_EN
    logic       wrap_pulse;
    logic       p_wrap_pulse;
`endif

    int vec_count  = 0;
    int miss_count = 0;

    lfsr_rng #(
        .WIDTH(4), .TAPS(32'h0000_000C), .SEED(32'h0000_000F), .OUT_BITS(2), .STEPS(2)
    ) dut (
        .clk(clk), .preset_n(preset_n), .enable(enable), .seed_load(seed_load),
        .seed(seed), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .state_q(state_q), .lockup(lockup)
`ifdef LFSR_WRAP_DET_EN
        , .wrap_pulse(wrap_pulse)
`endif
    );

    lfsr_rng #(
        .WIDTH(4), .TAPS(32'h0000_000C), .SEED(32'h0000_000F), .OUT_BITS(1), .STEPS(1)
    ) per (
        .clk(clk), .preset_n(p_preset_n), .enable(1'b1), .seed_load(1'b0),
        .seed(4'h0), .out_ready(1'b1), .out_valid(p_out_valid), .out_data(p_out_data),
        .state_q(p_state_q), .lockup(p_lockup)
`ifdef LFSR_WRAP_DET_EN
        , .wrap_pulse(p_wrap_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       sl;
        logic [3:0] sd;
        logic       rdy;
        logic [3:0] st;
        logic       v;
        logic [1:0] d;
        logic       lk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic en, input logic sl, input logic [3:0] sd,
                       input logic rdy, input logic [3:0] st, input logic v, input logic [1:0] d,
                       input logic lk);
        vecs.push_back('{rst_n, en, sl, sd, rdy, st, v, d, lk});
    endtask

    initial begin
        int shifts;
        int wraps[$];
        logic [3:0] prev;

        preset_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed = 4'h0; out_ready = 1'b0;
        p_preset_n = 1'b0;

        //  rst en sl seed rdy  state v  data lk
        add(0, 0, 0, 4'h0, 0, 4'hF, 0, 2'd0, 0);   // reset
        add(1, 1, 0, 4'h0, 0, 4'hE, 0, 2'd0, 0);
        add(1, 1, 0, 4'h0, 0, 4'hC, 1, 2'd3, 0);   // first word STEPS cycles after release
        add(1, 1, 0, 4'h0, 0, 4'hC, 1, 2'd3, 0);   // HOLD: enable does not shift
        add(1, 1, 0, 4'h0, 0, 4'hC, 1, 2'd3, 0);
        add(1, 1, 0, 4'h0, 1, 4'hC, 0, 2'd3, 0);   // accept, no shift
        add(1, 1, 0, 4'h0, 1, 4'h8, 0, 2'd3, 0);   // ready ignored while not valid
        add(1, 1, 0, 4'h0, 1, 4'h1, 1, 2'd0, 0);
        add(1, 1, 0, 4'h0, 1, 4'h1, 0, 2'd0, 0);
        add(1, 1, 0, 4'h0, 1, 4'h2, 0, 2'd0, 0);
        add(1, 1, 0, 4'h0, 1, 4'h4, 1, 2'd1, 0);
        add(1, 1, 0, 4'h0, 1, 4'h4, 0, 2'd1, 0);
        add(1, 1, 0, 4'h0, 1, 4'h9, 0, 2'd1, 0);
        add(1, 1, 0, 4'h0, 1, 4'h3, 1, 2'd0, 0);
        add(1, 1, 0, 4'h0, 1, 4'h3, 0, 2'd0, 0);
        add(1, 1, 0, 4'h0, 0, 4'h6, 0, 2'd0, 0);   // enable toggling in FILL
        add(1, 0, 0, 4'h0, 0, 4'h6, 0, 2'd0, 0);
        add(1, 1, 0, 4'h0, 0, 4'hD, 1, 2'd3, 0);
        add(1, 1, 0, 4'h0, 0, 4'hD, 1, 2'd3, 0);
        add(1, 1, 1, 4'h0, 0, 4'hF, 0, 2'd3, 1);   // zero seed -> SEED, lockup pulse
        add(1, 0, 0, 4'h0, 0, 4'hF, 0, 2'd3, 0);
        add(1, 0, 1, 4'h9, 0, 4'h9, 0, 2'd3, 0);
        add(1, 1, 0, 4'h0, 0, 4'h3, 0, 2'd3, 0);
        add(1, 1, 0, 4'h0, 0, 4'h6, 1, 2'd1, 0);
        add(1, 1, 1, 4'h5, 1, 4'h5, 0, 2'd1, 0);   // seed_load beats accept
        add(1, 1, 0, 4'h0, 0, 4'hB, 0, 2'd1, 0);
        add(1, 1, 0, 4'h0, 0, 4'h7, 1, 2'd1, 0);
        add(1, 1, 0, 4'h0, 1, 4'h7, 0, 2'd1, 0);
        add(1, 1, 0, 4'h0, 1, 4'hF, 0, 2'd1, 0);
        add(0, 1, 0, 4'h0, 1, 4'hF, 0, 2'd0, 0);   // reset mid-FILL
        add(1, 1, 0, 4'h0, 0, 4'hE, 0, 2'd0, 0);   // count restarted
        add(1, 1, 0, 4'h0, 0, 4'hC, 1, 2'd3, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            preset_n  = vecs[i].rst_n;
            enable    = vecs[i].en;
            seed_load = vecs[i].sl;
            seed      = vecs[i].sd;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            vec_count++;
            if (state_q !== vecs[i].st || out_valid !== vecs[i].v ||
                out_data !== vecs[i].d || lockup !== vecs[i].lk) begin
                miss_count++;
                $display("FAIL vec%0d: state=%h valid=%b data=%b lockup=%b, expected state=%h valid=%b data=%b lockup=%b",
                         i, state_q, out_valid, out_data, lockup,
                         vecs[i].st, vecs[i].v, vecs[i].d, vecs[i].lk);
            end
        end

        // Period check on the STEPS=1 instance: state must return to F every 15 shifts.
        @(posedge clk);
        #1;
        p_preset_n = 1'b1;
        shifts = 0;
        for (int c = 0; c < 80 && wraps.size() < 2; c++) begin
            prev = p_state_q;
            @(posedge clk);
            #1;
            if (p_state_q !== prev) begin
                shifts++;
                if (p_state_q == 4'hF) wraps.push_back(shifts);
            end
`ifdef LFSR_WRAP_DET_EN
            vec_count++;
            if (p_wrap_pulse !== (p_state_q !== prev && p_state_q == 4'hF)) begin
                miss_count++;
                $display("FAIL wrap_pulse cycle%0d: got %b state=%h prev=%h", c, p_wrap_pulse, p_state_q, prev);
            end
`endif
        end
        vec_count++;
        if (wraps.size() < 2) begin
            miss_count++;
            $display("FAIL period: only %0d returns to seed seen in budget, required 2", wraps.size());
        end else begin
            if (wraps[0] != 15) begin
                miss_count++;
                $display("FAIL period_first: %0d shifts, required 15", wraps[0]);
            end
            vec_count++;
            if (wraps[1] != 30) begin
                miss_count++;
                $display("FAIL period_second: %0d shifts, required 30", wraps[1]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
